// File: rtl/window_generator_pkg.sv
// -----------------------------------------------------------------------------
// window_generator_pkg
//   Shared definitions for the streaming window builder.
//   - win_state_t : FSM state encoding (IDLE, PRIME, STREAM)
//   - full_win()  : number of pixels in a window_width x window_width window
//   - row_bits()  : width of the row counter, never less than 1 bit
// -----------------------------------------------------------------------------
package window_generator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } win_state_t;

    // Packing-index helper: element count of one packed window.
    function automatic int full_win(input int window_width);
        return window_width * window_width;
    endfunction

    // ceil(log2(lines)) with a floor of one bit so a 1-line frame still
    // gets a legal counter.
    function automatic int row_bits(input int lines);
        int bits;
        bits = $clog2(lines);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/window_line_buffer.sv
// -----------------------------------------------------------------------------
// window_line_buffer
//   One line of pixel storage (im_width entries of color_width bits).
//   Read is combinational and returns the value stored before the current
//   edge; write happens on the clock edge while enable is high. The storage
//   is intentionally not reset: the window builder re-primes it before use.
//
// Ports
//   clk     : clock
//   enable  : write enable (the upstream pixel-valid)
//   addr    : column address, shared by read and write
//   wr_data : pixel written at addr
//   rd_data : pixel currently held at addr (previous line)
// -----------------------------------------------------------------------------
module window_line_buffer
    import window_generator_pkg::*;
#(
    parameter int color_width = 8,
    parameter int im_width    = 320,
    parameter int addr_width  = 9
) (
    input  logic                   clk,
    input  logic                   enable,
    input  logic [addr_width-1:0]  addr,
    input  logic [color_width-1:0] wr_data,
    output logic [color_width-1:0] rd_data
);

    logic [color_width-1:0] mem [im_width];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (enable) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_generator.sv
// -----------------------------------------------------------------------------
// window_generator
//   Turns a raster pixel stream (one pixel per clk while in_enable is high)
//   into packed window_width x window_width neighbourhoods for the local
//   filters downstream. window_width-1 line buffers hold the previous lines;
//   a shift array holds the current window. Only windows lying entirely
//   inside one frame and one set of lines are flagged.
//
//   Handshake: a pixel is accepted on every rising edge where in_enable=1;
//   there is no back-pressure. out_ready=1 means out_data holds a complete
//   window formed by the pixel accepted on the previous edge; out_data is
//   all zeros whenever out_ready=0. Dropping in_enable restarts the stream
//   at row 0, col 0.
//
//   Packing: element i = r*window_width + c sits at
//   out_data[(i+1)*color_width-1 : i*color_width]; r=0 is the oldest line,
//   c=0 the oldest column.
//
// Ports
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   in_enable : pixel valid; low stops and flushes the block
//   in_data   : pixel, sampled when in_enable=1
//   out_ready : out_data holds a complete valid window (registered)
//   out_data  : packed window
// -----------------------------------------------------------------------------
module window_generator
    import window_generator_pkg::*;
#(
    parameter int color_width  = 8,
    parameter int window_width = 3,
    parameter int im_width     = 320,
    parameter int im_height    = 240,
    parameter int addr_width   = 9
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             in_enable,
    input  logic [color_width-1:0]                           in_data,
    output logic                                             out_ready,
    output logic [color_width*full_win(window_width)-1:0]    out_data
);

    localparam int n_win  = full_win(window_width);
    localparam int row_w  = row_bits(im_height);
    localparam int n_lb   = window_width - 1;

    localparam logic [addr_width-1:0] col_last_val = addr_width'(im_width - 1);
    localparam logic [addr_width-1:0] col_min_val  = addr_width'(window_width - 1);
    localparam logic [row_w-1:0]      row_last_val = row_w'(im_height - 1);
    localparam logic [row_w-1:0]      row_prime_end = row_w'(window_width - 2);

    // FSM state, kept as a named signal so checkers can bind to it.
    win_state_t              state;
    logic [addr_width-1:0]   col;
    logic [row_w-1:0]        row;

    logic [color_width-1:0]  lb_rd   [n_lb];
    logic [color_width-1:0]  col_new [window_width];
    logic [color_width-1:0]  win     [window_width][window_width];
    logic [color_width*n_win-1:0] win_packed;

    logic col_last;
    logic row_last;

    assign col_last = (col == col_last_val);
    assign row_last = (row == row_last_val);

    // -------------------------------------------------------------------------
    // Line buffer chain: buffer 0 takes the live pixel, buffer k takes what
    // buffer k-1 held at this column, so buffer k returns line (current-k-1).
    // -------------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < n_lb; k++) begin : g_lb
            logic [color_width-1:0] lb_wr;
            if (k == 0) begin : g_head
                assign lb_wr = in_data;
            end else begin : g_tail
                assign lb_wr = lb_rd[k-1];
            end

            window_line_buffer #(
                .color_width (color_width),
                .im_width    (im_width),
                .addr_width  (addr_width)
            ) u_line (
                .clk     (clk),
                .enable  (in_enable),
                .addr    (col),
                .wr_data (lb_wr),
                .rd_data (lb_rd[k])
            );
        end
    endgenerate

    // New rightmost column: oldest line at r=0, live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < window_width; r++) begin
            col_new[r] = '0;
        end
        for (int r = 0; r < window_width - 1; r++) begin
            col_new[r] = lb_rd[window_width - 2 - r];
        end
        col_new[window_width-1] = in_data;
    end

    // -------------------------------------------------------------------------
    // Window shift array. Contents survive in_enable=0; priming overwrites
    // every element before the next flagged window.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < window_width; r++) begin
                for (int c = 0; c < window_width; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (in_enable) begin
            for (int r = 0; r < window_width; r++) begin
                for (int c = 0; c < window_width - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][window_width-1] <= col_new[r];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with position counters and registered out_ready.
    // out_ready uses the state and column of the pixel being accepted, so a
    // window is flagged only when all of its lines belong to this frame and
    // all of its columns belong to the current line.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            out_ready <= 1'b0;
        end else if (!in_enable) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            out_ready <= 1'b0;
        end else begin
            out_ready <= (state == STREAM) && (col >= col_min_val);

            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end

            case (state)
                IDLE: begin
                    state <= PRIME;
                end
                PRIME: begin
                    if (col_last && (row == row_prime_end)) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (col_last && row_last) begin
                        state <= PRIME;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output packing
    // -------------------------------------------------------------------------
    always_comb begin
        win_packed = '0;
        for (int r = 0; r < window_width; r++) begin
            for (int c = 0; c < window_width; c++) begin
                win_packed[(r*window_width + c)*color_width +: color_width] = win[r][c];
            end
        end
    end

    assign out_data = out_ready ? win_packed : '0;

endmodule

// File: tb/tb_window_generator.sv
// -----------------------------------------------------------------------------
// tb_window_generator
//   Directed bench for window_generator at window_width=3, im_width=8,
//   im_height=4, color_width=8 with pixel value = row*8+col.
// -----------------------------------------------------------------------------
module tb_window_generator;

    localparam int CW  = 8;
    localparam int WW  = 3;
    localparam int IMW = 8;
    localparam int IMH = 4;
    localparam int AW  = 3;
    localparam int DW  = CW * WW * WW;

    logic          clk;
    logic          rst_n;
    logic          in_enable;
    logic [CW-1:0] in_data;
    logic          out_ready;
    logic [DW-1:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    window_generator #(
        .color_width  (CW),
        .window_width (WW),
        .im_width     (IMW),
        .im_height    (IMH),
        .addr_width   (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_enable (in_enable),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic [CW-1:0] din;
        logic          exp_ready;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t frame_tab [2*IMW*IMH];

    // Independent model of the window ending at pixel (r, c) of a frame whose
    // pixels are r*8+c: element rr*3+cc holds pixel (r-2+rr, c-2+cc).
    function automatic logic [DW-1:0] exp_win(input int r, input int c);
        logic [DW-1:0] v;
        v = '0;
        for (int rr = 0; rr < WW; rr++) begin
            for (int cc = 0; cc < WW; cc++) begin
                v[(rr*WW + cc)*CW +: CW] = CW'((r - 2 + rr)*IMW + (c - 2 + cc));
            end
        end
        return v;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string name, input logic exp_ready, input logic [DW-1:0] exp_data);
        n_cmp++;
        if (out_ready !== exp_ready || out_data !== exp_data) begin
            n_err++;
            $display("FAIL %s: ready=%0b data=%h, expected ready=%0b data=%h",
                     name, out_ready, out_data, exp_ready, exp_data);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Drive one cycle, then sample 1 time unit after the edge.
    task automatic drive(input logic en, input logic [CW-1:0] val);
        in_enable = en;
        in_data   = val;
        @(posedge clk);
        #1;
    endtask

    // Drive 19 pixels 0..18 from a fresh start and check the fill sequence.
    task automatic fill_check(input string name);
        for (int p = 0; p < 19; p++) begin
            drive(1'b1, CW'(p));
            if (p < 18) check({name, "_prime"}, 1'b0, '0);
            else        check({name, "_first"}, 1'b1, exp_win(2, 2));
        end
    endtask

    // ---------------- test ----------------
    initial begin
        logic [DW-1:0] first_f1;
        logic [DW-1:0] first_f2;
        logic [DW-1:0] w;
        int            n_valid;
        int            sum;

        first_f1 = '0;
        first_f2 = '0;

        // Two back-to-back frames
        for (int p = 0; p < 2*IMW*IMH; p++) begin
            int r;
            int c;
            r = (p / IMW) % IMH;
            c = p % IMW;
            frame_tab[p].din       = CW'(r*IMW + c);
            frame_tab[p].exp_ready = (r >= 2) && (c >= 2);
            frame_tab[p].exp_data  = frame_tab[p].exp_ready ? exp_win(r, c) : '0;
        end

        // Reset state
        rst_n     = 1'b0;
        in_enable = 1'b0;
        in_data   = '0;
        #3;
        check("reset", 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0);
        check("idle_after_reset", 1'b0, '0);

        // Fill, line boundary and frame wrap from one table
        n_valid = 0;
        for (int p = 0; p < 2*IMW*IMH; p++) begin
            drive(1'b1, frame_tab[p].din);
            check($sformatf("frame_px%0d", p), frame_tab[p].exp_ready, frame_tab[p].exp_data);
            if (p < IMW*IMH && out_ready) n_valid++;
            if (p == 18) first_f1 = out_data;
            if (p == IMW*IMH + 18) first_f2 = out_data;
        end
        check_int("valid_per_frame", n_valid, 12);
        n_cmp++;
        if (first_f1 !== first_f2 || first_f1 !== exp_win(2, 2)) begin
            n_err++;
            $display("FAIL frame2_first: f1=%h f2=%h expected %h", first_f1, first_f2, exp_win(2, 2));
        end

        // Enable drop after pixel 21, then resume from 0
        for (int p = 0; p < 22; p++) begin
            drive(1'b1, CW'(p));
        end
        check("drop_last_valid", 1'b1, exp_win(2, 5));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'hAA);
            check("drop_idle", 1'b0, '0);
        end
        fill_check("resume");

        // Async reset mid-stream (pixel 19 is a valid window)
        drive(1'b0, '0);
        for (int p = 0; p < 20; p++) begin
            drive(1'b1, CW'(p));
        end
        check("pre_reset_valid", 1'b1, exp_win(2, 3));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b0, '0);
        in_enable = 1'b0;
        @(negedge clk);
        check("held_reset", 1'b0, '0);
        rst_n = 1'b1;
        fill_check("recover");

        // Constant 90 image; every flagged window must average to 90
        drive(1'b0, '0);
        n_valid = 0;
        for (int p = 0; p < IMW*IMH; p++) begin
            drive(1'b1, 8'd90);
            if (out_ready) begin
                n_valid++;
                w   = out_data;
                sum = 0;
                for (int i = 0; i < WW*WW; i++) begin
                    sum += int'(w[i*CW +: CW]);
                end
                check_int($sformatf("mean_px%0d", p), sum / (WW*WW), 90);
            end
        end
        check_int("const_valid_count", n_valid, 12);

        drive(1'b0, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/window_generator.md
Name: window_generator

Overview:
- Streaming window builder: turns a raster pixel stream (one pixel per clk) into packed window_width x window_width neighbourhoods.
- Sits directly upstream of the local filters (mean, median, etc.) and drives their in_enable/in_data window interface.
- Holds window_width-1 line buffers plus a window shift array.
- Flags only windows that lie fully inside one frame and one set of lines.

Parameters:
- color_width, 8, bits per pixel (1-12).
- window_width, 3, window side length (2-15).
- im_width, 320, pixels per line (>= window_width).
- im_height, 240, lines per frame (>= window_width).
- addr_width, 9, line-buffer address width; 2^addr_width >= im_width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_enable  in  1  pixel valid; low = stream stopped, block flushes.
- in_data  in  color_width  input pixel, sampled when in_enable=1.
- out_ready  out  1  out_data holds a complete valid window.
- out_data  out  color_width*window_width*window_width  packed window.

Behaviour:
- Packing: element i = r*window_width + c occupies bits [(i+1)*color_width-1 : i*color_width].
  - r=0 is the oldest line, r=window_width-1 the current line.
  - c=0 is the oldest column, c=window_width-1 the newest pixel.
- Counters:
  - col: 0..im_width-1, wraps to 0 and increments row.
  - row: 0..im_height-1, wraps to 0 at end of frame.
  - Both advance only on cycles with in_enable=1.
- Line buffers:
  - window_width-1 buffers, each im_width deep, all addressed by col.
  - Read is combinational (old data); write is synchronous.
  - Buffer k is written with the output of buffer k-1; buffer 0 is written with in_data.
- Window array: on each accepted pixel every row shifts left one column; the new column is {line buffer outputs oldest..newest, in_data}.
- FSM states:
  - IDLE: reset, or in_enable=0.
  - PRIME: row < window_width-1.
  - STREAM: row >= window_width-1.
- FSM transitions:
  - IDLE->PRIME on in_enable=1.
  - PRIME->STREAM when the last pixel of line window_width-2 is accepted.
  - STREAM->PRIME when the last pixel of the frame is accepted (row, col wrap to 0).
  - Any state->IDLE on in_enable=0.
- Latency: 1 cycle. A pixel accepted at edge t appears in out_data after edge t+1 settles.
- out_ready is registered. It is 1 in the cycle after accepting a pixel where the state is STREAM and col >= window_width-1; otherwise 0.
  - Windows straddling a line boundary are never flagged.
  - Windows straddling a frame boundary are never flagged.
- out_data = window array when out_ready=1, else all zeros.
- in_enable=0:
  - Synchronously clears col, row and out_ready.
  - FSM goes to IDLE.
  - Line buffer and window contents are left as-is; priming overwrites them before use.
- Resume after in_enable low: restarts at row 0, col 0. The next valid window appears only after (window_width-1)*im_width + window_width pixels.
- rst_n low:
  - Asynchronously clears col, row, FSM (IDLE), out_ready, and the window array.
  - Line buffer RAM is not reset.
- Width rules: col is addr_width bits; row is ceil(log2(im_height)) bits, with a minimum of 1.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, PRIME, STREAM).
  - Packing-index helper constant full_win = window_width*window_width.
- One sub-module, window_line_buffer: single line of im_width x color_width storage.
  - Combinational read, synchronous write enabled by in_enable.
  - Instanced window_width-1 times.

Test Plan (window_width=3, im_width=8, im_height=4, color_width=8, pixel value = row*8+col):
- Fill: rst_n release, then 19 consecutive enabled pixels (values 0..18).
  - out_ready is 0 for the first 18 cycles and 1 in cycle 19.
  - out_data bytes i0..i8 = 0,1,2,8,9,10,16,17,18.
- Line boundary: continue streaming.
  - out_ready low after pixels row3 col0 and col1.
  - High after row3 col2 with bytes 8,9,10,16,17,18,24,25,26.
  - Exactly 12 valid windows per frame.
- Frame wrap: stream two frames back to back.
  - out_ready stays 0 for pixels 0..17 of frame 2.
  - First window of frame 2 matches the first window of frame 1.
- Enable drop: deassert in_enable after pixel 21 for 3 cycles, then resume from value 0.
  - out_ready is 0 the cycle after the drop.
  - Next valid window again requires 19 pixels and equals 0,1,2,8,9,10,16,17,18.
- Async reset mid-stream: pulse rst_n low between clock edges during STREAM.
  - out_ready and out_data are 0 immediately.
  - Recovery behaves exactly as the Fill scenario.
- Integration: chain into the mean filter with a constant 90 image.
  - Every flagged output equals the mean of its window, i.e. 90 within the filter's shift-approximation tolerance.
